rr_arbiter_nport: RTL and testbench
===================================

// Module: rr_arbiter_nport
// PURPOSE
//  N-input round-robin arbiter with valid/ready on every input and on the output.
//  Successor to the two-input arbiter: parametrised port count, per-input back-pressure,
//  a registered output stage, and a grant-index output.
//  Sits between N producers and one shared downstream consumer.
// PARAMETERS
//  N_PORTS     4    number of requesters, >=1
//  DATA_WIDTH  16   payload width per beat
//  IDX_WIDTH   ($clog2(N_PORTS)>0 ? $clog2(N_PORTS) : 1)   width of the grant index (derived)
// PORTS
//  aclk           in   1                     clock, all logic on rising edge
//  areset_n       in   1                     synchronous reset, active-low
//  prev_valid_i   in   N_PORTS               per-input valid
//  prev_data_i    in   N_PORTS*DATA_WIDTH    packed payloads; port i = [i*DATA_WIDTH +: DATA_WIDTH]
//  prev_ready_o   out  N_PORTS               per-input ready, one-hot or zero
//  next_valid_o   out  1                     output beat valid (registered)
//  next_data_o    out  DATA_WIDTH            output payload (registered)
//  next_grant_o   out  IDX_WIDTH             source port of the current output beat (registered)
//  next_ready_i   in   1                     downstream ready
// BEHAVIOUR
//  - Reset (areset_n==0 at a rising edge):
//    next_valid_o=0, next_data_o=0, next_grant_o=0, last-grant pointer=N_PORTS-1.
//    Port 0 therefore has top priority after reset.
//  - Reset mid-operation discards any held output beat.
//    prev_ready_o is 0 while areset_n==0.
//  - can_load = !next_valid_o || next_ready_i.
//  - Grant selection (combinational):
//    - Search starts at port (ptr+1) mod N_PORTS and wraps to ptr.
//    - The first port with prev_valid_i=1 wins.
//    - No valid inputs means no grant.
//  - prev_ready_o[g] = can_load for the winner g; all other ready bits are 0.
//    At most one input handshake per cycle.
//  - Input handshake (prev_valid_i[g] && prev_ready_o[g]) at edge k:
//    - next_valid_o=1, next_data_o=data[g], next_grant_o=g from edge k.
//    - Latency is 1 cycle.
//    - ptr<=g.
//  - Output handshake without a new load: next_valid_o<=0.
//    Simultaneous output accept and input load gives back-to-back beats, so throughput is 1 beat/cycle.
//  - next_ready_i==0 with next_valid_o==1:
//    - data and grant are held stable;
//    - all prev_ready_o are 0;
//    - ptr is unchanged.
//  - ptr advances only on an accepted input beat; an idle cycle never moves it.
//  - Lone requester: granted every cycle it is valid. Starvation-free: any waiting port is served within N_PORTS beats.
//  - Wrap: after grant N_PORTS-1, port 0 has top priority.
//  - N_PORTS==1: arbitration is a pass-through register and next_grant_o is constant 0.
//  - Producers must hold prev_valid_i/prev_data_i until accepted; the arbiter does not check this.
// CONFIGURATION
//  RR_ARB_PKT_LOCK_EN defined:
//  - Adds ports prev_last_i (in, N_PORTS) and next_last_o (out, 1; reset value 0; registered with data).
//  - After the first accepted beat of port g with prev_last_i[g]==0, the grant is locked to g.
//    Other ports see ready=0 even if g deasserts valid.
//  - The lock releases on the accepted beat with prev_last_i[g]==1; ptr<=g then.
//  - Reset clears the lock.
//  RR_ARB_PKT_LOCK_EN undefined:
//  - No last ports.
//  - Every beat is arbitrated independently, as above.
// TESTING
//  1 Reset: hold areset_n=0 for 3 clocks with all valids=1 -> next_valid_o=0, next_data_o=0, next_grant_o=0, prev_ready_o=0.
//  2 Fairness: N_PORTS=4, all valid, data=16'hA000+i, next_ready_i=1.
//    -> output order 0,1,2,3,0,1,...; one beat per cycle; first beat one cycle after reset release.
//  3 Back-pressure: next_ready_i=0 for 5 cycles while beat from port 2 is held.
//    -> data and next_grant_o=2 stable, prev_ready_o=0; on release next beat comes from port 3.
//  4 Lone requester: only port 1 valid for 10 cycles -> 10 consecutive beats, grant=1.
//    Port 3 joins -> next grants alternate 3,1,3.
//  5 Count check:
//    - stimulus: port 0 sends 5 beats (16'hAAAA) starting at 100 ns; port 1 sends 15 beats (16'hBBBB) starting at 50 ns.
//    - required: exactly 5 and 15 beats out; no beat lost or duplicated; port 0 not waiting >1 beat once both are active.
//  6 Lock (RR_ARB_PKT_LOCK_EN): port 0 sends a 4-beat packet with last on beat 4 while port 1 is valid.
//    -> 4 contiguous port-0 beats, then port 1; next_last_o=1 only on beat 4.
//  Reset mid-stream: assert areset_n=0 with a held beat -> beat dropped, next_valid_o=0 next cycle, ptr back to port-0 priority.

Source files
------------

// File: rtl/rr_arbiter_nport.sv
// rtl/rr_arbiter_nport.sv - N-input round-robin arbiter with registered valid/ready output stage
// Optional packet lock (grant held until prev_last_i) enabled by defining RR_ARB_PKT_LOCK_EN.
module rr_arbiter_nport #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = ($clog2(N_PORTS) > 0 ? $clog2(N_PORTS) : 1)
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic [N_PORTS-1:0]            prev_valid_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0] prev_data_i,
    output logic [N_PORTS-1:0]            prev_ready_o,
`ifdef RR_ARB_PKT_LOCK_EN
    input  logic [N_PORTS-1:0]            prev_last_i,
    output logic                          next_last_o,
`endif
    output logic                          next_valid_o,
    output logic [DATA_WIDTH-1:0]         next_data_o,
    output logic [IDX_WIDTH-1:0]          next_grant_o,
    input  logic                          next_ready_i
);

    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  win;
    logic                  found;
    logic                  can_load;
    logic                  load;
    logic [DATA_WIDTH-1:0] data_arr [N_PORTS];

`ifdef RR_ARB_PKT_LOCK_EN
    logic                  locked;
    logic [IDX_WIDTH-1:0]  lock_port;
`endif

    for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
        assign data_arr[g] = prev_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Two descending passes: ports above ptr first, then wrap to ports up to ptr.
    // Descending order lets the lowest qualifying index be the last assignment.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (prev_valid_i[i] && (i > int'(ptr))) begin
                found = 1'b1;
                win   = IDX_WIDTH'(i);
            end
        end
        if (!found) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (prev_valid_i[i] && (i <= int'(ptr))) begin
                    found = 1'b1;
                    win   = IDX_WIDTH'(i);
                end
            end
        end
`ifdef RR_ARB_PKT_LOCK_EN
        if (locked) begin
            found = prev_valid_i[lock_port];
            win   = lock_port;
        end
`endif
    end

    assign can_load = !next_valid_o || next_ready_i;
    assign load     = areset_n && found && can_load;

    always_comb begin
        prev_ready_o = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            prev_ready_o[i] = load && (int'(win) == i);
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            next_valid_o <= 1'b0;
            next_data_o  <= '0;
            next_grant_o <= '0;
            ptr          <= IDX_WIDTH'(N_PORTS - 1);
`ifdef RR_ARB_PKT_LOCK_EN
            next_last_o  <= 1'b0;
            locked       <= 1'b0;
            lock_port    <= '0;
`endif
        end else if (load) begin
            next_valid_o <= 1'b1;
            next_data_o  <= data_arr[win];
            next_grant_o <= win;
            ptr          <= win;
`ifdef RR_ARB_PKT_LOCK_EN
            next_last_o  <= prev_last_i[win];
            locked       <= !prev_last_i[win];
            lock_port    <= win;
`endif
        end else if (next_ready_i) begin
            next_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_nport.sv
// tb/tb_rr_arbiter_nport.sv - self-checking bench for rr_arbiter_nport against a queue-based round-robin model
module tb_rr_arbiter_nport;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              aclk = 1'b0;
    logic              areset_n = 1'b0;
    logic [N-1:0]      prev_valid_i = '0;
    logic [N*DW-1:0]   prev_data_i = '0;
    logic [N-1:0]      prev_ready_o;
    logic              next_valid_o;
    logic [DW-1:0]     next_data_o;
    logic [IW-1:0]     next_grant_o;
    logic              next_ready_i = 1'b0;
`ifdef RR_ARB_PKT_LOCK_EN
    logic [N-1:0]      prev_last_i = '1;
    logic              next_last_o;
`endif

    rr_arbiter_nport #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .prev_valid_i (prev_valid_i),
        .prev_data_i  (prev_data_i),
        .prev_ready_o (prev_ready_o),
`ifdef RR_ARB_PKT_LOCK_EN
        .prev_last_i  (prev_last_i),
        .next_last_o  (next_last_o),
`endif
        .next_valid_o (next_valid_o),
        .next_data_o  (next_data_o),
        .next_grant_o (next_grant_o),
        .next_ready_i (next_ready_i)
    );

    always #5 aclk = ~aclk;

    // Producer queues: head of q[p] is what port p presents until accepted.
    logic [DW-1:0] q [N][$];
    int            checks = 0;
    int            failures = 0;
    int            m_ptr = N - 1;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_grant = 0;
    int            win;
    bit            can_load;
    logic [N-1:0]  exp_ready;
    bit            rdy = 1'b0;
    int            acc_port;

    task automatic apply_inputs();
        for (int p = 0; p < N; p++) begin
            prev_valid_i[p] = (q[p].size() > 0);
            if (q[p].size() > 0) prev_data_i[p*DW +: DW] = q[p][0];
            else                 prev_data_i[p*DW +: DW] = '0;
        end
        next_ready_i = rdy;
    endtask

    task automatic predict();
        can_load  = !m_valid || rdy;
        win       = -1;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (win < 0 && q[p].size() > 0) win = p;
        end
        exp_ready = '0;
        if (win >= 0 && can_load) exp_ready[win] = 1'b1;
    endtask

    task automatic pre_cycle();
        @(negedge aclk);
        apply_inputs();
        predict();
        #1;
    endtask

    task automatic post_cycle();
        @(posedge aclk);
        acc_port = -1;
        if (win >= 0 && can_load) begin
            m_valid  = 1'b1;
            m_data   = q[win].pop_front();
            m_grant  = win;
            m_ptr    = win;
            acc_port = win;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_ptr = N - 1; m_valid = 1'b0; m_data = '0; m_grant = 0;
    endtask

    task automatic test_reset();
        rdy = 1'b1;
        for (int p = 0; p < N; p++)
            for (int j = 0; j < 3; j++) q[p].push_back(DW'(16'hA000 + p));
        @(negedge aclk);
        apply_inputs();
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (next_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", next_valid_o); end
        checks++; if (next_data_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", next_data_o); end
        checks++; if (next_grant_o !== '0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", next_grant_o); end
        checks++; if (prev_ready_o !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", prev_ready_o); end
        model_reset();
        areset_n = 1'b1;
    endtask

    task automatic test_fairness();
        rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pre_cycle();
            checks++; if (prev_ready_o !== exp_ready) begin failures++; $display("FAIL fair_ready got=%b exp=%b", prev_ready_o, exp_ready); end
            post_cycle();
            checks++;
            if (next_valid_o !== 1'b1 || next_grant_o !== IW'(i % 4) || next_data_o !== DW'(16'hA000 + i % 4)) begin
                failures++;
                $display("FAIL fair_order beat=%0d got v=%b g=%0d d=%h exp v=1 g=%0d d=%h", i, next_valid_o, next_grant_o, next_data_o, i % 4, 16'hA000 + i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        rdy = 1'b1;
        q[2].push_back(16'h2222);
        pre_cycle();
        post_cycle();
        checks++; if (next_grant_o !== 2'd2 || next_data_o !== 16'h2222) begin failures++; $display("FAIL bp_load got g=%0d d=%h exp g=2 d=2222", next_grant_o, next_data_o); end
        q[3].push_back(16'h3333);
        q[0].push_back(16'h0A0A);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pre_cycle();
            checks++; if (prev_ready_o !== '0) begin failures++; $display("FAIL bp_ready got=%b exp=0", prev_ready_o); end
            post_cycle();
            checks++;
            if (next_valid_o !== 1'b1 || next_grant_o !== 2'd2 || next_data_o !== 16'h2222) begin
                failures++; $display("FAIL bp_hold got v=%b g=%0d d=%h exp v=1 g=2 d=2222", next_valid_o, next_grant_o, next_data_o);
            end
        end
        rdy = 1'b1;
        pre_cycle();
        post_cycle();
        checks++; if (next_grant_o !== 2'd3 || next_data_o !== 16'h3333) begin failures++; $display("FAIL bp_release got g=%0d d=%h exp g=3 d=3333", next_grant_o, next_data_o); end
        for (int i = 0; i < 2; i++) begin
            pre_cycle();
            checks++; if (prev_ready_o !== exp_ready) begin failures++; $display("FAIL bp_ready2 got=%b exp=%b", prev_ready_o, exp_ready); end
            post_cycle();
            checks++;
            if (next_valid_o !== m_valid || (m_valid && (next_data_o !== m_data || next_grant_o !== IW'(m_grant)))) begin
                failures++; $display("FAIL bp_out got v=%b d=%h g=%0d exp v=%b d=%h g=%0d", next_valid_o, next_data_o, next_grant_o, m_valid, m_data, m_grant);
            end
        end
    endtask

    task automatic test_lone_requester();
        int exp_g [4] = '{3, 1, 3, 1};
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) q[1].push_back(DW'(16'h1100 + i));
        for (int i = 0; i < 10; i++) begin
            pre_cycle();
            post_cycle();
            checks++;
            if (next_valid_o !== 1'b1 || next_grant_o !== 2'd1 || next_data_o !== DW'(16'h1100 + i)) begin
                failures++; $display("FAIL lone beat=%0d got v=%b g=%0d d=%h exp v=1 g=1 d=%h", i, next_valid_o, next_grant_o, next_data_o, 16'h1100 + i);
            end
        end
        q[1].push_back(16'h1111); q[1].push_back(16'h1112);
        q[3].push_back(16'h3331); q[3].push_back(16'h3332);
        for (int i = 0; i < 5; i++) begin
            pre_cycle();
            checks++; if (prev_ready_o !== exp_ready) begin failures++; $display("FAIL lone_ready got=%b exp=%b", prev_ready_o, exp_ready); end
            post_cycle();
            if (i < 4) begin
                checks++; if (next_valid_o !== 1'b1 || next_grant_o !== IW'(exp_g[i])) begin failures++; $display("FAIL lone_alt beat=%0d got g=%0d exp g=%0d", i, next_grant_o, exp_g[i]); end
            end else begin
                checks++; if (next_valid_o !== 1'b0) begin failures++; $display("FAIL lone_drain got v=%b exp v=0", next_valid_o); end
            end
        end
    endtask

    task automatic test_count();
        int out_cnt [N] = '{default: 0};
        int p1_run = 0;
        int p1_run_max = 0;
        int c = 0;
        bit done = 1'b0;
        while (!done && c < 400) begin
            if (c == 5)  for (int j = 0; j < 15; j++) q[1].push_back(16'hBBBB);
            if (c == 10) for (int j = 0; j < 5; j++)  q[0].push_back(16'hAAAA);
            rdy = ($urandom_range(0, 3) != 0);
            pre_cycle();
            if (next_valid_o && next_ready_i) out_cnt[next_grant_o]++;
            checks++; if (prev_ready_o !== exp_ready) begin failures++; $display("FAIL cnt_ready got=%b exp=%b", prev_ready_o, exp_ready); end
            post_cycle();
            checks++;
            if (next_valid_o !== m_valid || (m_valid && (next_data_o !== m_data || next_grant_o !== IW'(m_grant)))) begin
                failures++; $display("FAIL cnt_out got v=%b d=%h g=%0d exp v=%b d=%h g=%0d", next_valid_o, next_data_o, next_grant_o, m_valid, m_data, m_grant);
            end
            if (acc_port == 0) p1_run = 0;
            if (acc_port == 1 && q[0].size() > 0) p1_run++;
            if (p1_run > p1_run_max) p1_run_max = p1_run;
            c++;
            done = (c > 12) && (q[0].size() == 0) && (q[1].size() == 0) && !m_valid;
        end
        checks++; if (!done) begin failures++; $display("FAIL cnt_timeout got=not_drained exp=drained"); end
        checks++; if (out_cnt[0] !== 5) begin failures++; $display("FAIL cnt_port0 got=%0d exp=5", out_cnt[0]); end
        checks++; if (out_cnt[1] !== 15) begin failures++; $display("FAIL cnt_port1 got=%0d exp=15", out_cnt[1]); end
        checks++; if (p1_run_max > 1) begin failures++; $display("FAIL cnt_wait got=%0d exp<=1", p1_run_max); end
    endtask

    task automatic test_random();
        int c = 0;
        for (int i = 0; i < 300 || ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 || m_valid); i++) begin
            if (i >= 300) rdy = 1'b1;
            else begin
                rdy = ($urandom_range(0, 2) != 0);
                for (int p = 0; p < N; p++)
                    if ($urandom_range(0, 3) == 0 && q[p].size() < 3) q[p].push_back(DW'($urandom));
            end
            pre_cycle();
            checks++; if (prev_ready_o !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, prev_ready_o, exp_ready); end
            post_cycle();
            checks++;
            if (next_valid_o !== m_valid || (m_valid && (next_data_o !== m_data || next_grant_o !== IW'(m_grant)))) begin
                failures++; $display("FAIL rnd_out cyc=%0d got v=%b d=%h g=%0d exp v=%b d=%h g=%0d", i, next_valid_o, next_data_o, next_grant_o, m_valid, m_data, m_grant);
            end
            c = i;
            if (i > 400) break;
        end
        checks++; if (c > 400) begin failures++; $display("FAIL rnd_timeout got=not_drained exp=drained"); end
    endtask

    task automatic test_reset_midstream();
        for (int p = 0; p < N; p++) q[p].push_back(DW'(16'h5500 + p));
        q[0].push_back(16'h5510);
        rdy = 1'b0;
        pre_cycle();
        post_cycle();
        checks++; if (next_valid_o !== 1'b1) begin failures++; $display("FAIL mid_held got v=%b exp v=1", next_valid_o); end
        @(negedge aclk);
        apply_inputs();
        areset_n = 1'b0;
        @(posedge aclk);
        #1;
        checks++; if (next_valid_o !== 1'b0) begin failures++; $display("FAIL mid_drop got v=%b exp v=0", next_valid_o); end
        checks++; if (prev_ready_o !== '0) begin failures++; $display("FAIL mid_ready got=%b exp=0", prev_ready_o); end
        model_reset();
        areset_n = 1'b1;
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pre_cycle();
            post_cycle();
            checks++;
            if (next_valid_o !== m_valid || (m_valid && (next_data_o !== m_data || next_grant_o !== IW'(m_grant)))) begin
                failures++; $display("FAIL mid_out got v=%b d=%h g=%0d exp v=%b d=%h g=%0d", next_valid_o, next_data_o, next_grant_o, m_valid, m_data, m_grant);
            end
            if (i == 0) begin
                checks++; if (next_grant_o !== 2'd0) begin failures++; $display("FAIL mid_prio got g=%0d exp g=0", next_grant_o); end
            end
        end
    endtask

`ifdef RR_ARB_PKT_LOCK_EN
    task automatic test_lock();
        @(negedge aclk);
        prev_valid_i = '0;
        areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            prev_valid_i = (k < 4) ? 4'b0011 : 4'b0010;
            prev_data_i  = '0;
            prev_data_i[0 +: DW]  = DW'(16'hC000 + k);
            prev_data_i[DW +: DW] = 16'hD001;
            prev_last_i  = (k == 3) ? 4'b0011 : 4'b0010;
            next_ready_i = 1'b1;
            @(posedge aclk);
            #1;
            checks++;
            if (k < 4 && (next_grant_o !== 2'd0 || next_data_o !== DW'(16'hC000 + k) || next_last_o !== (k == 3))) begin
                failures++; $display("FAIL lock_beat k=%0d got g=%0d d=%h l=%b exp g=0 d=%h l=%b", k, next_grant_o, next_data_o, next_last_o, 16'hC000 + k, k == 3);
            end else if (k == 4 && (next_grant_o !== 2'd1 || next_last_o !== 1'b1)) begin
                failures++; $display("FAIL lock_release got g=%0d l=%b exp g=1 l=1", next_grant_o, next_last_o);
            end
            @(negedge aclk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_lone_requester();
        test_count();
        test_random();
        test_reset_midstream();
`ifdef RR_ARB_PKT_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
